multi_ctrl: RTL and testbench

Multi-cycle MIPS main control unit. Successor to the single-cycle decoder: a Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a memory-ready handshake. Adds ADDI and BNE support, an illegal-opcode trap and a retired-instruction counter. Drives the shared-memory multi-cycle datapath (IR, A/B, ALUOut, MDR registers).

---
 rtl/multi_ctrl_pkg.sv | 62 ++++++
 rtl/multi_ctrl_outdec.sv | 78 +++++++
 rtl/multi_ctrl.sv | 117 +++++++++++
 tb/tb_multi_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: opcodes, FSM
// states, datapath mux selects and the packed control word.
package multi_ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/multi_ctrl_outdec.sv
// Moore output decode: state (plus mem_ready for the handshake states and the
// latched BNE flag) to control word. Unused encodings decode to all zeros.
module multi_ctrl_outdec
  import multi_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   is_bne,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = is_bne;
        ctrl.retire        = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS main control: state register, next-state logic, opcode-class
// latch, illegal-opcode trap and retired-instruction counter.
module multi_ctrl
  import multi_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_nx;
  logic   is_store, is_bne, op_legal;
  ctrl_t  cw, ctrl;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Only the opcode class survives DECODE; op is not trusted afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store <= 1'b0;
      is_bne   <= 1'b0;
    end else if (state == DECODE) begin
      is_store <= (op == OP_SW);
      is_bne   <= (op == OP_BNE);
    end
  end

  always_comb begin
    op_legal = 1'b1;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:   state_nx = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:          state_nx = EXEC;
          OP_LW, OP_SW:  state_nx = MEMADDR;
          OP_BEQ, OP_BNE: state_nx = BRANCH;
          OP_J:          state_nx = JUMP;
          OP_ADDI:       state_nx = ADDI_EX;
          default:       state_nx = FETCH;
        endcase
      end
      MEMADDR: state_nx = is_store ? MEMWR : MEMRD;
      MEMRD:   state_nx = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_nx = mem_ready ? FETCH : MEMWR;
      EXEC:    state_nx = RWB;
      ADDI_EX: state_nx = ADDI_WB;
      default: state_nx = FETCH;
    endcase
  end

  multi_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .is_bne    (is_bne),
    .ctrl      (cw)
  );

  // Reset blanks every output, including the FETCH word of the reset state.
  always_comb begin
    ctrl = cw;
    if (rst) ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)              retired <= '0;
    else if (ctrl.retire) retired <= retired + CNT_W'(1);
  end

  assign illegal     = !rst && (state == DECODE) && !op_legal;
  assign instr_done  = ctrl.retire;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNE    = ctrl.branch_ne;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUop       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_multi_ctrl.sv
// Scoreboard bench for multi_ctrl: each cycle's expected control word and
// retired count are queued as stimulus is driven and compared off-edge.
module tb_multi_ctrl;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J_OP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct packed {
    logic        r;
    logic [5:0]  o;
    logic        mr;
    logic [18:0] cw;
  } step_t;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] op = '0;
  logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic MemToReg, RegDst, RegWrite, ALUSrcA, illegal, instr_done;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] retired;
  logic [18:0] obs;

  logic [22:0] sb[$];
  logic [22:0] exp_v;
  logic [3:0]  ret_m = '0;
  int vectors = 0, miscompares = 0;

  multi_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .illegal(illegal), .instr_done(instr_done), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
                illegal, instr_done};

  // Expected words, bit order as in obs: [18]PCWrite .. [1]illegal [0]instr_done
  function automatic logic [18:0] x_fetch(input logic rdy);
    logic [18:0] v = '0;
    v[18] = rdy; v[14] = 1'b1; v[12] = rdy; v[7:6] = 2'b01;
    return v;
  endfunction
  function automatic logic [18:0] x_decode(input logic ill);
    logic [18:0] v = '0;
    v[7:6] = 2'b11; v[1] = ill;
    return v;
  endfunction
  function automatic logic [18:0] x_addr();
    logic [18:0] v = '0;
    v[8] = 1'b1; v[7:6] = 2'b10;
    return v;
  endfunction
  function automatic logic [18:0] x_memrd();
    logic [18:0] v = '0;
    v[15] = 1'b1; v[14] = 1'b1;
    return v;
  endfunction
  function automatic logic [18:0] x_memwb();
    logic [18:0] v = '0;
    v[9] = 1'b1; v[11] = 1'b1; v[0] = 1'b1;
    return v;
  endfunction
  function automatic logic [18:0] x_memwr(input logic rdy);
    logic [18:0] v = '0;
    v[13] = 1'b1; v[15] = 1'b1; v[0] = rdy;
    return v;
  endfunction
  function automatic logic [18:0] x_exec();
    logic [18:0] v = '0;
    v[8] = 1'b1; v[5:4] = 2'b10;
    return v;
  endfunction
  function automatic logic [18:0] x_rwb();
    logic [18:0] v = '0;
    v[9] = 1'b1; v[10] = 1'b1; v[0] = 1'b1;
    return v;
  endfunction
  function automatic logic [18:0] x_branch(input logic ne);
    logic [18:0] v = '0;
    v[8] = 1'b1; v[5:4] = 2'b01; v[17] = 1'b1; v[3:2] = 2'b01; v[16] = ne; v[0] = 1'b1;
    return v;
  endfunction
  function automatic logic [18:0] x_jump();
    logic [18:0] v = '0;
    v[18] = 1'b1; v[3:2] = 2'b10; v[0] = 1'b1;
    return v;
  endfunction
  function automatic logic [18:0] x_addiwb();
    logic [18:0] v = '0;
    v[9] = 1'b1; v[0] = 1'b1;
    return v;
  endfunction
  function automatic step_t mk(input logic r, input logic [5:0] o, input logic mr,
                               input logic [18:0] cw);
    step_t s;
    s.r = r; s.o = o; s.mr = mr; s.cw = cw;
    return s;
  endfunction

  task automatic test_reset();
    step_t s[$];
    for (int k = 0; k < 3; k++) s.push_back(mk(1'b1, R_OP, 1'b1, 19'h0));
    s.push_back(mk(1'b0, R_OP, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, R_OP, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, R_OP, 1'b1, x_exec()));
    s.push_back(mk(1'b0, R_OP, 1'b1, x_rwb()));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL reset_r[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    step_t s[$];
    s.push_back(mk(1'b0, LW, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, LW, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, LW, 1'b1, x_addr()));
    s.push_back(mk(1'b0, LW, 1'b1, x_memrd()));
    s.push_back(mk(1'b0, LW, 1'b1, x_memwb()));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL lw[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_sw_stall();
    step_t s[$];
    s.push_back(mk(1'b0, SW, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, SW, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, SW, 1'b1, x_addr()));
    for (int k = 0; k < 3; k++) s.push_back(mk(1'b0, SW, 1'b0, x_memwr(1'b0)));
    s.push_back(mk(1'b0, SW, 1'b1, x_memwr(1'b1)));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL sw_stall[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_addi_fetch_stall();
    step_t s[$];
    s.push_back(mk(1'b0, ADDI, 1'b0, x_fetch(1'b0)));
    s.push_back(mk(1'b0, ADDI, 1'b0, x_fetch(1'b0)));
    s.push_back(mk(1'b0, ADDI, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, ADDI, 1'b0, x_decode(1'b0)));
    s.push_back(mk(1'b0, ADDI, 1'b0, x_addr()));
    s.push_back(mk(1'b0, ADDI, 1'b0, x_addiwb()));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL addi[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    s.push_back(mk(1'b0, BNE, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, BNE, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, BEQ, 1'b1, x_branch(1'b1)));
    s.push_back(mk(1'b0, BEQ, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, BEQ, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, BNE, 1'b1, x_branch(1'b0)));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    step_t s[$];
    s.push_back(mk(1'b0, BAD, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, BAD, 1'b1, x_decode(1'b1)));
    s.push_back(mk(1'b0, J_OP, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, J_OP, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, J_OP, 1'b1, x_jump()));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_rst_abort();
    step_t s[$];
    s.push_back(mk(1'b0, LW, 1'b1, x_fetch(1'b1)));
    s.push_back(mk(1'b0, LW, 1'b1, x_decode(1'b0)));
    s.push_back(mk(1'b0, LW, 1'b1, x_addr()));
    s.push_back(mk(1'b0, LW, 1'b0, x_memrd()));
    s.push_back(mk(1'b0, LW, 1'b0, x_memrd()));
    s.push_back(mk(1'b1, LW, 1'b1, 19'h0));
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL rst_abort[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    step_t s[$];
    logic [3:0] ret_start;
    ret_start = ret_m;
    for (int k = 0; k < 16; k++) begin
      s.push_back(mk(1'b0, J_OP, 1'b1, x_fetch(1'b1)));
      s.push_back(mk(1'b0, J_OP, 1'b1, x_decode(1'b0)));
      s.push_back(mk(1'b0, J_OP, 1'b1, x_jump()));
    end
    foreach (s[i]) begin
      rst = s[i].r; op = s[i].o; mem_ready = s[i].mr;
      sb.push_back({s[i].cw, ret_m});
      #1;
      exp_v = sb.pop_front();
      vectors++;
      if ({obs, retired} !== exp_v) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h want %h", i, {obs, retired}, exp_v);
      end
      if (s[i].r) ret_m = '0; else if (s[i].cw[0]) ret_m++;
      @(negedge clk);
    end
    #1;
    vectors++;
    if (retired !== ret_start) begin
      miscompares++;
      $display("FAIL wrap_final: retired %0d want %0d", retired, ret_start);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    op = '0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw_stall();
    test_addi_fetch_stall();
    test_branch();
    test_illegal();
    test_rst_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
